// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIF coprocessor: decoded ops, stage bundles,
// the LSU FSM states and the X-interface memory/commit payloads.
package fir_xifu_pkg;

    localparam int unsigned X_ID_WIDTH = 4;

    typedef enum logic [1:0] {
        INSTR_NONE,
        INSTR_XFIRLW,
        INSTR_XFIRSW,
        INSTR_XFIRDOTP
    } fir_xifu_instr_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        KILLED
    } fir_xifu_lsu_state_e;

    typedef struct packed {
        fir_xifu_instr_e         instr;
        logic [X_ID_WIDTH-1:0]   id;
        logic [4:0]              rs1;
        logic [4:0]              rd;
        logic [31:0]             base;
        logic [31:0]             offset;
        logic [31:0]             wdata;
    } fir_xifu_id2ex_t;

    typedef struct packed {
        fir_xifu_instr_e         instr;
        logic [X_ID_WIDTH-1:0]   id;
        logic [4:0]              rs1;
        logic [4:0]              rd;
        logic [31:0]             result;
    } fir_xifu_ex2wb_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]   id;
        logic [31:0]             addr;
        logic [1:0]              mode;
        logic                    we;
        logic [2:0]              size;
        logic [3:0]              be;
        logic [1:0]              attr;
        logic [31:0]             wdata;
        logic                    last;
        logic                    spec;
    } x_mem_req_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]   id;
        logic                    commit_kill;
    } x_commit_t;

    // Post-increment addressing: the request goes to base, not base+offset.
    function automatic x_mem_req_t mk_mem_req(input fir_xifu_id2ex_t op);
        x_mem_req_t r;
        r       = '0;
        r.id    = op.id;
        r.addr  = op.base;
        r.we    = (op.instr == INSTR_XFIRSW);
        r.size  = 3'b010;
        r.be    = 4'hF;
        r.wdata = (op.instr == INSTR_XFIRSW) ? op.wdata : 32'h0;
        r.last  = 1'b1;
        return r;
    endfunction

    function automatic fir_xifu_ex2wb_t mk_wb(input fir_xifu_id2ex_t op,
                                              input logic [31:0] res);
        fir_xifu_ex2wb_t w;
        w.instr  = op.instr;
        w.id     = op.id;
        w.rs1    = op.rs1;
        w.rd     = op.rd;
        w.result = res;
        return w;
    endfunction

endpackage

// File: rtl/cv32e40x_if_xif.sv
// Reduced X-interface carrying only the memory, memory-result and
// commit channels the FIR LSU touches.
interface cv32e40x_if_xif;

    logic                     mem_valid;
    logic                     mem_ready;
    fir_xifu_pkg::x_mem_req_t mem_req;

    logic                     mem_result_valid;

    logic                     commit_valid;
    fir_xifu_pkg::x_commit_t  commit;

    modport coproc_mem (
        output mem_valid,
        output mem_req,
        input  mem_ready
    );

    modport coproc_mem_result (
        input mem_result_valid
    );

    modport coproc_commit (
        input commit_valid,
        input commit
    );

endinterface

// File: rtl/fir_xifu_lsu_cnt.sv
// Saturating counter of issued-but-unanswered memory requests.
module fir_xifu_lsu_cnt #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign full_o  = (cnt_q == CW'(MAX_OUTSTANDING));
    assign empty_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !full_o) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec_i && !inc_i && !empty_o) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fir_xifu_lsu.sv
// FIR coprocessor load/store unit: issues one X-interface memory request
// per accepted load/store and writes back the post-incremented base.
module fir_xifu_lsu
    import fir_xifu_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    cv32e40x_if_xif.coproc_mem        xif_mem_o,
    cv32e40x_if_xif.coproc_mem_result xif_mem_result_i,
    cv32e40x_if_xif.coproc_commit     xif_commit_i,
    input  fir_xifu_id2ex_t          id2ex_i,
    input  logic                     id2ex_valid_i,
    output logic                     id2ex_ready_o,
    output fir_xifu_ex2wb_t          ex2wb_o,
    output logic                     ex2wb_valid_o
);

    fir_xifu_lsu_state_e state_q, state_d;
    fir_xifu_id2ex_t     op_q, op_d;
    fir_xifu_ex2wb_t     ex2wb_q, ex2wb_d;
    logic                ex2wb_valid_q, ex2wb_valid_d;

    logic full, empty, accept, is_mem, issue, retire, kill;

    assign accept = id2ex_valid_i && id2ex_ready_o;
    assign is_mem = (id2ex_i.instr == INSTR_XFIRLW) ||
                    (id2ex_i.instr == INSTR_XFIRSW);
    assign issue  = (state_q == REQ) && xif_mem_o.mem_ready;
    assign retire = xif_mem_result_i.mem_result_valid && !empty;
    assign kill   = xif_commit_i.commit_valid &&
                    xif_commit_i.commit.commit_kill &&
                    (xif_commit_i.commit.id == op_q.id);

    // Combinational so the FSM reset drops mem_valid without waiting a clock.
    assign id2ex_ready_o       = !rst_i && (state_q == IDLE) && !full;
    assign xif_mem_o.mem_valid = (state_q == REQ);
    assign xif_mem_o.mem_req   = (state_q == REQ) ? mk_mem_req(op_q) : '0;

    assign ex2wb_o       = ex2wb_q;
    assign ex2wb_valid_o = ex2wb_valid_q;

    fir_xifu_lsu_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (issue),
        .dec_i  (retire),
        .full_o (full),
        .empty_o(empty)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        ex2wb_d       = ex2wb_q;
        ex2wb_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && is_mem) begin
                    op_d    = id2ex_i;
                    state_d = REQ;
                end else if (accept) begin
                    ex2wb_d       = mk_wb(id2ex_i, 32'h0);
                    ex2wb_valid_d = 1'b1;
                end
            end
            REQ: begin
                // A handshake wins over a same-cycle kill: the request is out.
                if (issue) begin
                    ex2wb_d       = mk_wb(op_q, op_q.base + op_q.offset);
                    ex2wb_valid_d = 1'b1;
                    state_d       = IDLE;
                end else if (kill) begin
                    state_d = KILLED;
                end
            end
            KILLED: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            op_q          <= '0;
            ex2wb_q       <= '0;
            ex2wb_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            ex2wb_q       <= ex2wb_d;
            ex2wb_valid_q <= ex2wb_valid_d;
        end
    end

endmodule

// File: tb/tb_fir_xifu_lsu.sv
// Self-checking bench for fir_xifu_lsu: directed table, corner-case
// sequences and randomized ops against a counting reference model.
module tb_fir_xifu_lsu;
    import fir_xifu_pkg::*;

    localparam int MAX = 2;

    logic            clk;
    logic            rst;
    fir_xifu_id2ex_t id2ex;
    logic            id2ex_valid;
    logic            id2ex_ready;
    fir_xifu_ex2wb_t ex2wb;
    logic            ex2wb_valid;

    cv32e40x_if_xif xif ();

    fir_xifu_lsu #(
        .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .xif_mem_o       (xif.coproc_mem),
        .xif_mem_result_i(xif.coproc_mem_result),
        .xif_commit_i    (xif.coproc_commit),
        .id2ex_i         (id2ex),
        .id2ex_valid_i   (id2ex_valid),
        .id2ex_ready_o   (id2ex_ready),
        .ex2wb_o         (ex2wb),
        .ex2wb_valid_o   (ex2wb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int mdl_cnt = 0;

    typedef struct {
        fir_xifu_instr_e ins;
        logic [3:0]      id;
        logic [31:0]     base;
        logic [31:0]     off;
        logic [31:0]     wd;
        int              stall;
        int              kill_at;
        logic [31:0]     exp_res;
        logic            exp_we;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic retire();
        xif.mem_result_valid = 1'b1;
        @(negedge clk);
        xif.mem_result_valid = 1'b0;
        if (mdl_cnt > 0) mdl_cnt--;
    endtask

    task automatic run_op(input fir_xifu_instr_e ins, input logic [3:0] id,
                          input logic [31:0] base, input logic [31:0] off,
                          input logic [31:0] wd, input int stall,
                          input int kill_at, input bit retire_hs,
                          input logic [31:0] exp_res, input logic exp_we);
        bit is_mem;
        bit killed;
        bit ret_now;
        is_mem = (ins == INSTR_XFIRLW) || (ins == INSTR_XFIRSW);
        killed = 1'b0;
        chk("ready_idle", 32'(id2ex_ready), 32'(mdl_cnt < MAX));
        id2ex        = '0;
        id2ex.instr  = ins;
        id2ex.id     = id;
        id2ex.rs1    = 5'd10;
        id2ex.rd     = {1'b0, id};
        id2ex.base   = base;
        id2ex.offset = off;
        id2ex.wdata  = wd;
        id2ex_valid  = 1'b1;
        @(negedge clk);
        id2ex_valid = 1'b0;
        if (is_mem) begin
            for (int c = 0; c <= stall; c++) begin
                chk("mem_valid", 32'(xif.mem_valid), 32'd1);
                chk("req_addr", xif.mem_req.addr, base);
                chk("req_we", 32'(xif.mem_req.we), 32'(exp_we));
                chk("req_wdata", xif.mem_req.wdata, exp_we ? wd : 32'h0);
                chk("req_id", 32'(xif.mem_req.id), 32'(id));
                chk("req_attr",
                    32'({xif.mem_req.size, xif.mem_req.be, xif.mem_req.last,
                         xif.mem_req.spec, xif.mem_req.mode, xif.mem_req.attr}),
                    32'({3'b010, 4'hF, 1'b1, 1'b0, 2'b00, 2'b00}));
                chk("ready_busy", 32'(id2ex_ready), 32'd0);
                if (c == kill_at) begin
                    xif.commit_valid       = 1'b1;
                    xif.commit.id          = id;
                    xif.commit.commit_kill = 1'b1;
                    killed = (c != stall);
                end else begin
                    xif.commit_valid       = (c % 2 == 1);
                    xif.commit.id          = id ^ 4'h1;
                    xif.commit.commit_kill = 1'b1;
                end
                xif.mem_ready = (c == stall);
                ret_now = retire_hs && (c == stall) && (mdl_cnt > 0);
                xif.mem_result_valid = ret_now;
                @(negedge clk);
                xif.commit_valid     = 1'b0;
                xif.mem_ready        = 1'b0;
                xif.mem_result_valid = 1'b0;
                if (killed) break;
                if (c == stall) begin
                    if (ret_now) mdl_cnt--;
                    mdl_cnt++;
                end
            end
            if (killed) begin
                chk("kill_mem_valid", 32'(xif.mem_valid), 32'd0);
                chk("kill_no_wb", 32'(ex2wb_valid), 32'd0);
                chk("kill_ready", 32'(id2ex_ready), 32'd0);
                @(negedge clk);
                chk("kill_no_wb2", 32'(ex2wb_valid), 32'd0);
                return;
            end
        end
        chk("wb_valid", 32'(ex2wb_valid), 32'd1);
        chk("wb_result", ex2wb.result, exp_res);
        chk("wb_id", 32'(ex2wb.id), 32'(id));
        chk("wb_rd", 32'(ex2wb.rd), 32'(id));
        chk("mem_valid_done", 32'(xif.mem_valid), 32'd0);
        @(negedge clk);
        chk("wb_pulse", 32'(ex2wb_valid), 32'd0);
    endtask

    initial begin
        fir_xifu_instr_e ins;
        logic [31:0] b, o, w;
        int st, ka;

        tbl[0] = '{INSTR_XFIRLW,   4'd1, 32'h0000_1000, 32'd4,
                   32'h0,          0, -1, 32'h0000_1004, 1'b0};
        tbl[1] = '{INSTR_XFIRSW,   4'd2, 32'h0000_2000, 32'h10,
                   32'hDEAD_BEEF,  3, -1, 32'h0000_2010, 1'b1};
        tbl[2] = '{INSTR_XFIRDOTP, 4'd3, 32'h0000_0005, 32'd6,
                   32'h0,          0, -1, 32'h0000_0000, 1'b0};
        tbl[3] = '{INSTR_XFIRLW,   4'd4, 32'hFFFF_FFFC, 32'd8,
                   32'h0,          1, -1, 32'h0000_0004, 1'b0};
        tbl[4] = '{INSTR_XFIRSW,   4'd6, 32'h0000_3001, 32'hFFFF_FFFF,
                   32'h1234_5678,  1, -1, 32'h0000_3000, 1'b1};
        tbl[5] = '{INSTR_XFIRLW,   4'd7, 32'h8000_0000, 32'h8000_0000,
                   32'h0,          2,  2, 32'h0000_0000, 1'b0};

        rst = 1'b1;
        id2ex = '0;
        id2ex_valid = 1'b0;
        xif.mem_ready = 1'b0;
        xif.mem_result_valid = 1'b0;
        xif.commit_valid = 1'b0;
        xif.commit = '0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(id2ex_ready), 32'd0);
        chk("rst_mem_valid", 32'(xif.mem_valid), 32'd0);
        chk("rst_mem_addr", xif.mem_req.addr, 32'h0);
        chk("rst_wb_valid", 32'(ex2wb_valid), 32'd0);
        chk("rst_wb", ex2wb.result, 32'h0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(id2ex_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].ins, tbl[i].id, tbl[i].base, tbl[i].off, tbl[i].wd,
                   tbl[i].stall, tbl[i].kill_at, 1'b0,
                   tbl[i].exp_res, tbl[i].exp_we);
            while (mdl_cnt > 0) retire();
        end

        // Kill of id 5 mid-stall leaves the count untouched.
        run_op(INSTR_XFIRLW, 4'd5, 32'h0000_5000, 32'd4, 32'h0, 3, 1, 1'b0,
               32'h0000_5004, 1'b0);
        // Two loads fill the window; one retire reopens it next cycle.
        run_op(INSTR_XFIRLW, 4'd8, 32'h100, 32'd4, 32'h0, 0, -1, 1'b0,
               32'h104, 1'b0);
        run_op(INSTR_XFIRLW, 4'd9, 32'h200, 32'd4, 32'h0, 0, -1, 1'b0,
               32'h204, 1'b0);
        chk("full_ready", 32'(id2ex_ready), 32'd0);
        @(negedge clk);
        chk("full_ready_hold", 32'(id2ex_ready), 32'd0);
        retire();
        chk("reopen_ready", 32'(id2ex_ready), 32'd1);

        // Reset while a request is pending, with one already outstanding.
        id2ex = '0;
        id2ex.instr = INSTR_XFIRLW;
        id2ex.id = 4'd10;
        id2ex.base = 32'h0000_6000;
        id2ex_valid = 1'b1;
        @(negedge clk);
        id2ex_valid = 1'b0;
        chk("pre_rst_mem_valid", 32'(xif.mem_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_mem_valid", 32'(xif.mem_valid), 32'd0);
        chk("async_mem_addr", xif.mem_req.addr, 32'h0);
        chk("async_ready", 32'(id2ex_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mdl_cnt = 0;
        #1;
        chk("post_rst_ready", 32'(id2ex_ready), 32'd1);
        chk("post_rst_mem_valid", 32'(xif.mem_valid), 32'd0);
        run_op(INSTR_XFIRLW, 4'd11, 32'h300, 32'd4, 32'h0, 0, -1, 1'b0,
               32'h304, 1'b0);
        run_op(INSTR_XFIRLW, 4'd12, 32'h400, 32'd4, 32'h0, 0, -1, 1'b0,
               32'h404, 1'b0);
        chk("post_rst_full", 32'(id2ex_ready), 32'd0);
        retire();
        retire();

        // Randomized ops against the outstanding-count model.
        for (int it = 0; it < 60; it++) begin
            if (mdl_cnt == MAX) begin
                chk("rnd_full", 32'(id2ex_ready), 32'd0);
                retire();
                continue;
            end
            if ($urandom_range(0, 3) == 0) retire();
            case ($urandom_range(0, 2))
                0: ins = INSTR_XFIRLW;
                1: ins = INSTR_XFIRSW;
                default: ins = INSTR_XFIRDOTP;
            endcase
            b  = $urandom;
            o  = $urandom;
            w  = $urandom;
            st = $urandom_range(0, 3);
            ka = ($urandom_range(0, 3) == 0) ? $urandom_range(0, st) : -1;
            run_op(ins, 4'($urandom), b, o, w, st, ka,
                   1'($urandom_range(0, 1)),
                   (ins == INSTR_XFIRDOTP) ? 32'h0 : b + o,
                   ins == INSTR_XFIRSW);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fir_xifu_lsu.md
FIR_XIFU_LSU -- requirements
Module: fir_xifu_lsu

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 2, maximum accepted-but-unanswered memory requests (range 1..4).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 xif_mem_o  cv32e40x_if_xif.coproc_mem  -  memory request channel: mem_valid, mem_ready, mem_req.
REQ-005 xif_mem_result_i  cv32e40x_if_xif.coproc_mem_result  -  monitored only; mem_result_valid retires one outstanding request.
REQ-006 xif_commit_i  cv32e40x_if_xif.coproc_commit  -  commit/kill by instruction id.
REQ-007 id2ex_i  input  fir_xifu_id2ex_t  decoded op: instr, id, rs1, rd, base[31:0], offset[31:0], wdata[31:0].
REQ-008 id2ex_valid_i / id2ex_ready_o  input / output  1 / 1  op handshake; transfer when both high.
REQ-009 ex2wb_o  output  fir_xifu_ex2wb_t  instr, id, rs1, rd, result[31:0], registered.
REQ-010 ex2wb_valid_o  output  1  ex2wb_o holds a new op for exactly one cycle.

Function
REQ-011 FSM states: IDLE, REQ, KILLED; reset state IDLE.
REQ-012 IDLE: id2ex_ready_o=1 iff outstanding count < MAX_OUTSTANDING; else 0.
REQ-013 IDLE, accepted INSTR_XFIRLW/INSTR_XFIRSW -> REQ; op registered; mem_valid asserted from next cycle.
REQ-014 IDLE, accepted non-memory op (e.g. INSTR_XFIRDOTP) -> stays IDLE; ex2wb_valid_o=1 next cycle, result=0.
REQ-015 mem_req: id=op id, addr=base (post-increment), we=1 for XFIRSW else 0, size=3'b010, be=4'hF, wdata=wdata for XFIRSW else 0, mode=0, attr=0, last=1, spec=0.
REQ-016 REQ: mem_valid=1 and all mem_req fields stable until mem_ready=1.
REQ-017 REQ, mem_valid&mem_ready -> IDLE; outstanding count +1; ex2wb_valid_o=1 next cycle, result=base+offset mod 2^32.
REQ-018 Address not aligned: issue unmodified; alignment faults are the core's responsibility.
REQ-019 id2ex_ready_o=0 in REQ and KILLED.
REQ-020 Kill: commit_valid & commit_kill & commit.id==held id in REQ and no same-cycle handshake -> KILLED; mem_valid=0 from next cycle; no ex2wb_valid_o.
REQ-021 Kill in the same cycle as handshake: request counts as issued; ex2wb_valid_o still pulses; the WB stage discards it.
REQ-022 KILLED -> IDLE after one cycle; no counter change.
REQ-023 Outstanding count -1 per mem_result_valid; simultaneous issue and retire leaves count unchanged.
REQ-024 Retire at count 0 is ignored (saturate at 0); count never exceeds MAX_OUTSTANDING.
REQ-025 Commit with a non-matching id, or without kill, has no effect.

Reset
REQ-026 While rst_i=1: state IDLE, count 0, mem_valid 0, mem_req 0, ex2wb_o 0, ex2wb_valid_o 0, id2ex_ready_o 0.
REQ-027 Reset during REQ drops mem_valid asynchronously; the in-flight op is lost.
REQ-028 id2ex_ready_o may rise only in the first cycle after rst_i deasserts.

Structure
REQ-029 fir_xifu_id2ex_t, fir_xifu_ex2wb_t, INSTR_* codes and the FSM state enum belong in fir_xifu_pkg.
REQ-030 Outstanding counter is a sub-module, fir_xifu_lsu_cnt (inc, dec, full, empty).

Verification
REQ-031 XFIRLW base=0x1000, offset=4, mem_ready high -> one-cycle mem_valid, addr=0x1000, we=0; ex2wb result=0x1004.
REQ-032 XFIRSW wdata=0xDEADBEEF, mem_ready low 3 cycles -> mem_req stable for 4 cycles; handshake in cycle 4.
REQ-033 Kill on id 5 during stall -> mem_valid falls next cycle; no ex2wb_valid_o; count unchanged.
REQ-034 Two loads, no mem_result -> count 2 and id2ex_ready_o=0; one mem_result_valid -> ready returns next cycle.
REQ-035 base=0xFFFFFFFC, offset=8 -> result=0x00000004 (wrap-around).
REQ-036 rst_i pulse in REQ -> mem_valid 0 immediately; after release: IDLE, count 0.
